// File: rtl/clk_divider_multi_if.sv
// rtl/clk_divider_multi_if.sv - run/ratio controls and divided-clock outputs of clk_divider_multi
interface clk_divider_multi_if #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 32
);
  logic [CHANNELS-1:0]       I_EN;
  logic [CHANNELS*CNT_W-1:0] I_DIV;
  logic                      I_LOAD;
  logic [CHANNELS-1:0]       O_CLK;
  logic [CHANNELS-1:0]       O_TICK;

  modport master (
    output I_EN, I_DIV, I_LOAD,
    input  O_CLK, O_TICK
  );

  modport slave (
    input  I_EN, I_DIV, I_LOAD,
    output O_CLK, O_TICK
  );
endinterface

// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - multi-channel programmable clock divider with period-aligned ratio reload
// O_TICK generation is built only when CLKDIV_TICK_EN is defined; otherwise O_TICK is tied low.
module clk_divider_multi #(
  parameter int CHANNELS    = 2,
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 100000000
) (
  input logic                I_CLK,
  input logic                I_RST_N,
  clk_divider_multi_if.slave bus
);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

  function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  // Odd ratios put the extra cycle in the high phase.
  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] n);
    return n - (n >> 1);
  endfunction

  logic [CHANNELS-1:0] clk_vec;
  logic [CHANNELS-1:0] tick_vec;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] req;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             wrap;

    assign req  = clamp_ratio(bus.I_DIV[c*CNT_W +: CNT_W]);
    assign wrap = (cnt_q >= act_q - ONE);

    always_comb begin
      cnt_d      = cnt_q;
      act_d      = act_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      clk_d      = 1'b0;

      if (bus.I_LOAD) begin
        pend_d     = req;
        pend_vld_d = 1'b1;
      end

      // A load sampled on the same edge as a wrap governs the new period directly.
      if (!bus.I_EN[c] || wrap) begin
        if (bus.I_LOAD) begin
          act_d = req;
        end else if (pend_vld_q) begin
          act_d = pend_q;
        end
        pend_vld_d = 1'b0;
      end

      if (!bus.I_EN[c]) begin
        cnt_d = act_d - ONE;
      end else if (wrap) begin
        cnt_d = '0;
        clk_d = 1'b1;
      end else begin
        cnt_d = cnt_q + ONE;
        clk_d = (cnt_d < high_len(act_q));
      end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
        cnt_q      <= DIV_RST - ONE;
        act_q      <= DIV_RST;
        pend_q     <= DIV_RST;
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        act_q      <= act_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        clk_q      <= clk_d;
      end
    end

    assign clk_vec[c] = clk_q;

`ifdef CLKDIV_TICK_EN
    logic tick_q;

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= bus.I_EN[c] && wrap;
      end
    end

    assign tick_vec[c] = tick_q;
`else
    assign tick_vec[c] = 1'b0;
`endif
  end

  assign bus.O_CLK  = clk_vec;
  assign bus.O_TICK = tick_vec;
endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - directed checks of clk_divider_multi waveforms, reloads, enables and reset
module tb_clk_divider_multi;
  logic I_CLK = 1'b0;
  logic I_RST_N;
  int   vectors = 0;
  int   miscompares = 0;

  clk_divider_multi_if #(.CHANNELS(2), .CNT_W(32)) bus ();

  clk_divider_multi #(
    .CHANNELS   (2),
    .CNT_W      (32),
    .DIV_DEFAULT(10)
  ) dut (
    .I_CLK  (I_CLK),
    .I_RST_N(I_RST_N),
    .bus    (bus)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input logic [1:0] eclk, input logic [1:0] etick, input string tag, input int idx);
    logic [1:0] exp_tick;
`ifdef CLKDIV_TICK_EN
    exp_tick = etick;
`else
    exp_tick = 2'b00;
`endif
    vectors++;
    assert (bus.O_CLK === eclk) else begin
      miscompares++;
      $error("FAIL %s[%0d] O_CLK observed=%b expected=%b", tag, idx, bus.O_CLK, eclk);
    end
    vectors++;
    assert (bus.O_TICK === exp_tick) else begin
      miscompares++;
      $error("FAIL %s[%0d] O_TICK observed=%b expected=%b", tag, idx, bus.O_TICK, exp_tick);
    end
  endtask

  // Cycle k uses pattern bit n-1-k; after checking cycle ld_at a one-cycle load of ld_div is driven.
  task automatic run_pat(input int n, input logic [31:0] c0, input logic [31:0] t0,
                         input logic [31:0] c1, input logic [31:0] t1,
                         input int ld_at, input logic [63:0] ld_div, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge I_CLK);
      chk({c1[n-1-k], c0[n-1-k]}, {t1[n-1-k], t0[n-1-k]}, tag, k);
      if (k == ld_at) begin
        bus.I_LOAD = 1'b1;
        bus.I_DIV  = ld_div;
      end else begin
        bus.I_LOAD = 1'b0;
      end
    end
  endtask

  initial begin
    I_RST_N    = 1'b0;
    bus.I_EN   = 2'b00;
    bus.I_LOAD = 1'b0;
    bus.I_DIV  = '0;

    #2;
    chk(2'b00, 2'b00, "reset_async", 0);
    @(negedge I_CLK);
    chk(2'b00, 2'b00, "reset_hold", 0);

    I_RST_N    = 1'b1;
    bus.I_DIV  = {32'd5, 32'd4};
    bus.I_LOAD = 1'b1;
    run_pat(1, 32'b0, 32'b0, 32'b0, 32'b0, -1, 64'd0, "load_disabled");
    bus.I_EN = 2'b11;

    run_pat(20, 32'b11001100110011001100, 32'b10001000100010001000,
                32'b11100111001110011100, 32'b10000100001000010000,
                19, {32'd1, 32'd0}, "n4_n5");

    run_pat(8, 32'b10101010, 32'b10101010, 32'b10101010, 32'b10101010,
               7, {32'd5, 32'd4}, "clamp_n2");

    run_pat(2, 32'b11, 32'b10, 32'b11, 32'b10, 1, {32'd5, 32'd6}, "reload_pre");
    run_pat(14, 32'b00111000111000, 32'b00100000100000,
                32'b10011100111001, 32'b00010000100001,
                13, {32'd5, 32'd4}, "reload_4to6");

    run_pat(13, 32'b1100110110110, 32'b1000100100100,
                32'b1100111001110, 32'b0000100001000,
                3, {32'd5, 32'd3}, "wrap_load_4to3");

    run_pat(2, 32'b11, 32'b10, 32'b01, 32'b01, -1, 64'd0, "pre_disable");
    bus.I_EN = 2'b10;
    run_pat(3, 32'b000, 32'b000, 32'b110, 32'b000, -1, 64'd0, "ch0_disabled");
    bus.I_EN = 2'b11;
    run_pat(5, 32'b11011, 32'b10010, 32'b01110, 32'b01000, -1, 64'd0, "ch0_reenable");

    #2;
    I_RST_N = 1'b0;
    #1;
    chk(2'b00, 2'b00, "reset_mid", 0);
    @(negedge I_CLK);
    chk(2'b00, 2'b00, "reset_mid_hold", 0);
    I_RST_N = 1'b1;

    run_pat(20, 32'b11111000001111100000, 32'b10000000001000000000,
                32'b11111000001111100000, 32'b10000000001000000000,
                -1, 64'd0, "default_n10");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clk_divider_multi.md
# clk_divider_multi

Multi-channel, runtime-programmable clock divider: the parametrised successor to the fixed single-ratio divider. From one system clock it produces CHANNELS independent divided clock-enable waveforms. Each channel has its own divide ratio, enable and single-cycle tick. Ratios can be reloaded glitch-free at period boundaries. It feeds the display-scan, debounce and CPU-step clock domains of the MIPS board top.

## Interface

- CHANNELS, 2: number of independent output channels (1..8).
- CNT_W, 32: counter and ratio width per channel; maximum ratio 2^CNT_W-1.
- DIV_DEFAULT, 100000000: ratio loaded into every channel at reset.

- I_CLK  in  1  system clock; all state updates on posedge.
- I_RST_N  in  1  reset, asynchronous, active-low.
- I_EN  in  CHANNELS  per-channel run enable.
- I_DIV  in  CHANNELS*CNT_W  per-channel requested ratio N; channel c occupies bits [c*CNT_W +: CNT_W].
- I_LOAD  in  1  single-cycle strobe; captures all I_DIV fields.
- O_CLK  out  CHANNELS  divided clock per channel, registered.
- O_TICK  out  CHANNELS  one-cycle pulse coincident with each O_CLK rising edge, registered.

## Operation

Per-channel state: cnt (CNT_W), div_act, div_pend, pend_vld.
- Effective ratio: N = max(I_DIV field, 2). Values 0 and 1 are clamped to 2, so an output never runs faster than I_CLK/2.
- Period: cnt runs 0..N-1. When cnt equals N-1, the next increment wraps it to 0 (the "wrap").
- O_CLK is 1 for cnt in [0, H-1], where H = N - floor(N/2), and 0 otherwise. For odd N the high phase is longer by one cycle.
- O_TICK is 1 for exactly the cycle in which cnt = 0, i.e. once per period.
- Load handling:
  - I_LOAD writes div_pend and sets pend_vld on all channels.
  - On a channel's next wrap, div_act takes div_pend and pend_vld clears.
  - A second I_LOAD before the wrap overwrites div_pend.
  - If I_LOAD and a wrap occur on the same edge, the newly sampled I_DIV governs the period starting at that wrap.
- Disabled channel (I_EN[c]=0):
  - cnt is forced to div_act-1 (terminal), O_CLK and O_TICK are forced to 0, and any pending load is applied immediately.
  - A high phase cut short by a disable is permitted.
- Channels are fully independent. CHANNELS=1 must elaborate.

## Timing

- Reset values (asynchronous, immediate):
  - O_CLK=0 and O_TICK=0.
  - Per channel: div_act=DIV_DEFAULT, cnt=DIV_DEFAULT-1, pend_vld=0.
- Enable latency: on the first posedge with I_EN[c]=1, cnt wraps to 0 and both O_CLK[c] and O_TICK[c] go 1. Latency is one cycle.
- Steady state:
  - O_TICK[c] is high 1 cycle in every N.
  - O_CLK[c] is high H cycles and low floor(N/2) cycles.
- Load latency: the new ratio takes effect at the first wrap at or after the I_LOAD edge. No partial period exists at either the old or the new ratio.
- Reset deasserting mid-operation restarts every channel from the reset state. No O_CLK glitch is produced beyond the asynchronous drop to 0.

## Configuration

- CLKDIV_TICK_EN defined: O_TICK is generated as specified.
- CLKDIV_TICK_EN undefined:
  - O_TICK is tied to 0 and its registers are removed.
  - The port remains for a stable interface.
  - O_CLK behaviour is unchanged.

## Test plan

- Reset, then I_LOAD with ch0 N=4 and ch1 N=5, then enable both:
  - ch0 O_CLK is 1100 repeating, with O_TICK every 4 cycles.
  - ch1 O_CLK is 11100 repeating, with O_TICK every 5 cycles.
  - The first rising edge on each channel appears 1 cycle after enable.
- Load N=0 and N=1 -> each behaves as N=2: O_CLK alternates 1010 and O_TICK is high every other cycle.
- ch0 running at N=4; pulse I_LOAD with N=6 at cnt=1 -> the current period finishes as 4 cycles, then 111000 repeats. There is no intermediate period length.
- I_LOAD coincident with the wrap edge, N changing 4->3 -> the period starting at that edge is 110, and O_TICK has no duplicate or missing pulse.
- Drop I_EN[0] mid-high -> O_CLK[0] is 0 on the next edge. Re-enable -> rising edge and tick 1 cycle later, with ch1 undisturbed throughout.
- Assert I_RST_N low mid-period -> outputs are 0 immediately. Release with DIV_DEFAULT=10 overridden -> 5-high/5-low waveform. Build without CLKDIV_TICK_EN -> O_TICK is constantly 0.
